hazard_unit: RTL

- Parametrised hazard and forwarding controller for the in-order pipelined MIPS core.
- Keeps a scoreboard of in-flight register writers for the stages after ID.
- From that scoreboard and the instruction in ID it produces:
  - load-use stall,
  - branch flush,
  - per-operand forwarding selects.
- Stage count, load data-ready stage and branch resolve stage are parameters. It also keeps saturating stall/flush performance counters.

---
 rtl/hazard_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit
// Hazard and forwarding controller for the in-order pipelined MIPS core.
// It keeps a scoreboard of in-flight register writers for the post-ID stages
// (index 0 = EX ... DEPTH-1 = WB). From that scoreboard and the instruction in
// ID it derives:
//   - the load-use stall,
//   - the branch flush,
//   - the per-operand forwarding selects.
// It also keeps saturating stall and flush performance counters.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_*                       instruction currently in ID (sources, uses, dest)
//   branch_taken               redirect resolved at scoreboard index BRANCH_STAGE
//   stall                      hold PC and IF/ID, bubble into ID/EX
//   flush_if_id, flush_id_ex   clear the wrong-path pipeline registers
//   fwd_sel_rs, fwd_sel_rt     0 = regfile, k = post-ID pipeline register k
//   stall_cnt, flush_cnt       saturating performance counters
module hazard_unit #(
  parameter int DEPTH        = 3,
  parameter int REG_AW       = 5,
  parameter int LOAD_STAGE   = 2,
  parameter int BRANCH_STAGE = 0,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_reg_write,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              branch_taken,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [2:0]        fwd_sel_rs,
  output logic [2:0]        fwd_sel_rt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Scoreboard: entry s describes the instruction now in post-ID stage s.
  logic [DEPTH-1:0]             v_r;
  logic [DEPTH-1:0]             ld_r;
  logic [DEPTH-1:0][REG_AW-1:0] addr_r;
  logic [CNT_W-1:0]             stall_cnt_r;
  logic [CNT_W-1:0]             flush_cnt_r;

  logic [3:0] look_rs_s;
  logic [3:0] look_rt_s;
  logic       hazard_s;
  logic       stall_s;

  // Returns {hazard, sel}. The scan runs oldest to youngest, so the last hit
  // (lowest s) wins. A load whose data is not yet available at s+1 is a hazard
  // and reports sel 0.
  function automatic logic [3:0] lookup(
    input logic                         en,
    input logic [REG_AW-1:0]            src,
    input logic [DEPTH-1:0]             v,
    input logic [DEPTH-1:0][REG_AW-1:0] a,
    input logic [DEPTH-1:0]             ld
  );
    logic [3:0] r;
    r = 4'd0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (en && v[s] && (a[s] == src)) begin
        if (ld[s] && ((s + 1) < LOAD_STAGE)) begin
          r = {1'b1, 3'd0};
        end else begin
          r = {1'b0, 3'(s + 1)};
        end
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Operand matching against the registered scoreboard.
  always_comb begin
    look_rs_s = lookup(id_valid & id_use_rs & (id_rs != '0), id_rs, v_r, addr_r, ld_r);
    look_rt_s = lookup(id_valid & id_use_rt & (id_rt != '0), id_rt, v_r, addr_r, ld_r);
    hazard_s  = look_rs_s[3] | look_rt_s[3];
    // A flush squashes the consumer anyway, so it overrides the stall.
    stall_s   = hazard_s & ~branch_taken & ~reset;
  end

  // Output drive: everything reads zero while reset is held.
  always_comb begin
    stall       = stall_s;
    flush_if_id = branch_taken & ~reset;
    flush_id_ex = branch_taken & ~reset;
    fwd_sel_rs  = reset ? 3'd0 : look_rs_s[2:0];
    fwd_sel_rt  = reset ? 3'd0 : look_rt_s[2:0];
    stall_cnt   = reset ? {CNT_W{1'b0}} : stall_cnt_r;
    flush_cnt   = reset ? {CNT_W{1'b0}} : flush_cnt_r;
  end

  // Scoreboard shift, wrong-path invalidation and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_r         <= '0;
      ld_r        <= '0;
      addr_r      <= '0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      for (int s = 1; s < DEPTH; s++) begin
        // Entries younger than the branch are on the wrong path.
        v_r[s]    <= v_r[s-1] & ~(branch_taken & ((s - 1) < BRANCH_STAGE));
        ld_r[s]   <= ld_r[s-1];
        addr_r[s] <= addr_r[s-1];
      end
      v_r[0]    <= id_valid & id_reg_write & (id_wr_addr != '0) & ~stall_s & ~branch_taken;
      ld_r[0]   <= id_is_load;
      addr_r[0] <= id_wr_addr;
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (branch_taken && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

endmodule
